am_search_ctrl: RTL and testbench

- Sequences associative-memory (AM) search for one encoded query hypervector against NUM_CLASSES stored class hypervectors.
- Each class HV is streamed in NUM_CHUNKS chunks. The controller issues {class, chunk} requests to the external overlap/popcount unit and accumulates each returned overlap count into a per-class similarity.
- It keeps a running argmax, replacing the combinational compare tree with a time-multiplexed comparator.
- It presents the winning class on a valid/ready result interface to the classifier top level.

---
 rtl/am_search_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_am_search_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_search_ctrl.sv
// Associative-memory search sequencer: streams {class, chunk} requests to the overlap unit,
// accumulates per-class similarity and keeps a running argmax. Define AM_MARGIN_EN for runner-up margin output.
module am_search_ctrl #(
    parameter int NUM_CLASSES = 26,
    parameter int CLASS_W     = 5,
    parameter int NUM_CHUNKS  = 40,
    parameter int CHUNK_IDX_W = 6,
    parameter int CNT_W       = 8,
    parameter int SIM_W       = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [CLASS_W-1:0]     req_class,
    output logic [CHUNK_IDX_W-1:0] req_chunk,
    input  logic                   rsp_valid,
    input  logic [CNT_W-1:0]       rsp_count,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [CLASS_W-1:0]     result_class,
    output logic [SIM_W-1:0]       result_sim,
    output logic                   err_spurious
`ifdef AM_MARGIN_EN
    ,
    output logic [SIM_W-1:0]       result_margin
`endif
);

    localparam int TOTAL_REQ = NUM_CLASSES * NUM_CHUNKS;
    localparam int OUT_W     = $clog2(TOTAL_REQ + 1);
    localparam logic [CLASS_W-1:0]     LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);
    localparam logic [CHUNK_IDX_W-1:0] LAST_CHUNK = CHUNK_IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    logic [CLASS_W-1:0]       rsp_class;
    logic [CHUNK_IDX_W-1:0]   rsp_chunk;
    logic [OUT_W-1:0]         outstanding;
    logic [SIM_W-1:0]         acc;
    logic [SIM_W-1:0]         best_sim;
    logic [CLASS_W-1:0]       best_class;

    logic                     req_acc;
    logic                     rsp_acc;
    logic                     last_chunk;
    logic                     last_rsp;
    logic                     new_best;
    logic [SIM_W-1:0]         sum_sat;
    logic [SIM_W-1:0]         nb_sim;
    logic [CLASS_W-1:0]       nb_class;
`ifdef AM_MARGIN_EN
    logic [SIM_W-1:0]         second_sim;
    logic [SIM_W-1:0]         nb_second;
`endif

    function automatic logic [SIM_W-1:0] sat_add(input logic [SIM_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [SIM_W:0] s;
        s = {1'b0, a} + {{(SIM_W + 1 - CNT_W){1'b0}}, b};
        return s[SIM_W] ? {SIM_W{1'b1}} : s[SIM_W-1:0];
    endfunction

    // Single shared comparator: the class finishing this cycle is compared against the running best.
    always_comb begin
        req_acc    = (state == RUN) && req_valid && req_ready;
        rsp_acc    = (state == RUN) && rsp_valid && (outstanding != '0);
        sum_sat    = sat_add(acc, rsp_count);
        last_chunk = (rsp_chunk == LAST_CHUNK);
        last_rsp   = rsp_acc && last_chunk && (rsp_class == LAST_CLASS);
        new_best   = (sum_sat > best_sim) || (rsp_class == '0);
        nb_class   = new_best ? rsp_class : best_class;
        nb_sim     = new_best ? sum_sat : best_sim;
`ifdef AM_MARGIN_EN
        if (new_best)
            nb_second = best_sim;
        else if (sum_sat > second_sim)
            nb_second = sum_sat;
        else
            nb_second = second_sim;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            req_valid    <= 1'b0;
            req_class    <= '0;
            req_chunk    <= '0;
            rsp_class    <= '0;
            rsp_chunk    <= '0;
            outstanding  <= '0;
            acc          <= '0;
            best_sim     <= '0;
            best_class   <= '0;
            result_valid <= 1'b0;
            result_class <= '0;
            result_sim   <= '0;
            err_spurious <= 1'b0;
`ifdef AM_MARGIN_EN
            second_sim    <= '0;
            result_margin <= '0;
`endif
        end else begin
            // A response with nothing in flight cannot belong to any request.
            if (rsp_valid && (outstanding == '0))
                err_spurious <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        req_valid   <= 1'b1;
                        req_class   <= '0;
                        req_chunk   <= '0;
                        rsp_class   <= '0;
                        rsp_chunk   <= '0;
                        outstanding <= '0;
                        acc         <= '0;
                        best_sim    <= '0;
                        best_class  <= '0;
`ifdef AM_MARGIN_EN
                        second_sim  <= '0;
`endif
                    end
                end

                RUN: begin
                    if (req_acc) begin
                        if (req_chunk == LAST_CHUNK) begin
                            if (req_class == LAST_CLASS) begin
                                req_valid <= 1'b0;
                            end else begin
                                req_chunk <= '0;
                                req_class <= req_class + 1'b1;
                            end
                        end else begin
                            req_chunk <= req_chunk + 1'b1;
                        end
                    end

                    outstanding <= outstanding + OUT_W'(req_acc) - OUT_W'(rsp_acc);

                    if (rsp_acc) begin
                        if (last_chunk) begin
                            acc        <= '0;
                            best_sim   <= nb_sim;
                            best_class <= nb_class;
                            rsp_chunk  <= '0;
                            rsp_class  <= rsp_class + 1'b1;
`ifdef AM_MARGIN_EN
                            second_sim <= nb_second;
`endif
                        end else begin
                            acc       <= sum_sat;
                            rsp_chunk <= rsp_chunk + 1'b1;
                        end

                        if (last_rsp) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                            result_class <= nb_class;
                            result_sim   <= nb_sim;
`ifdef AM_MARGIN_EN
                            result_margin <= nb_sim - nb_second;
`endif
                        end
                    end
                end

                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_am_search_ctrl.sv
// Self-checking bench for am_search_ctrl: table-driven searches, randomized overlap-unit timing and
// counts checked against a top-level similarity/argmax model, plus reset-abort and DONE-hold sequences.
module tb_am_search_ctrl;

    localparam int NUM_CLASSES = 26;
    localparam int CLASS_W     = 5;
    localparam int NUM_CHUNKS  = 40;
    localparam int CHUNK_IDX_W = 6;
    localparam int CNT_W       = 8;
    localparam int SIM_W       = 13;
    localparam int TOTAL       = NUM_CLASSES * NUM_CHUNKS;
    localparam int SIM_MAX     = (1 << SIM_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   busy;
    logic                   req_valid;
    logic                   req_ready;
    logic [CLASS_W-1:0]     req_class;
    logic [CHUNK_IDX_W-1:0] req_chunk;
    logic                   rsp_valid;
    logic [CNT_W-1:0]       rsp_count;
    logic                   result_valid;
    logic                   result_ready;
    logic [CLASS_W-1:0]     result_class;
    logic [SIM_W-1:0]       result_sim;
    logic                   err_spurious;
`ifdef AM_MARGIN_EN
    logic [SIM_W-1:0]       result_margin;
`endif

    am_search_ctrl #(
        .NUM_CLASSES(NUM_CLASSES), .CLASS_W(CLASS_W), .NUM_CHUNKS(NUM_CHUNKS),
        .CHUNK_IDX_W(CHUNK_IDX_W), .CNT_W(CNT_W), .SIM_W(SIM_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class), .req_chunk(req_chunk),
        .rsp_valid(rsp_valid), .rsp_count(rsp_count),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_class(result_class), .result_sim(result_sim), .err_spurious(err_spurious)
`ifdef AM_MARGIN_EN
        , .result_margin(result_margin)
`endif
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int hot_a; int hot_b; int hot_val; int base;
        int ready_pct; int lat_min; int lat_max; int hold;
        int exp_class; int exp_sim; int exp_margin; int exp_lat;
    } vec_t;

    typedef struct { int due; int cnt; } rsp_t;

    vec_t vecs[5];
    rsp_t q[$];
    int   cnt_tab[NUM_CLASSES][NUM_CHUNKS];
    int   ready_pct, lat_min, lat_max;
    int   obs_lat, obs_issued, order_err, stab_err;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int hot_a, input int hot_b, input int hot_val, input int base);
        for (int c = 0; c < NUM_CLASSES; c++)
            for (int k = 0; k < NUM_CHUNKS; k++)
                cnt_tab[c][k] = (c == hot_a || c == hot_b) ? hot_val : base;
    endtask

    // Reference: whole-class sums, lowest-index argmax, margin to best of the rest.
    task automatic model(output int mc, output int ms, output int mm);
        int sims[NUM_CLASSES];
        int s, second;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            s = 0;
            for (int k = 0; k < NUM_CHUNKS; k++) s += cnt_tab[c][k];
            sims[c] = (s > SIM_MAX) ? SIM_MAX : s;
        end
        mc = 0;
        for (int c = 1; c < NUM_CLASSES; c++)
            if (sims[c] > sims[mc]) mc = c;
        second = 0;
        for (int c = 0; c < NUM_CLASSES; c++)
            if (c != mc && sims[c] > second) second = sims[c];
        ms = sims[mc];
        mm = ms - second;
    endtask

    function automatic bit outputs_zero();
        return !busy && !req_valid && !result_valid && !err_spurious &&
               req_class == '0 && req_chunk == '0 && result_class == '0 && result_sim == '0
`ifdef AM_MARGIN_EN
               && result_margin == '0
`endif
               ;
    endfunction

    // Acts as the overlap unit; all driving and sampling happens on the falling edge.
    task automatic run_search(input int abort_at);
        int e, s, n, last_due, d, ec, ek, v;
        bit stalled, got;
        logic [CLASS_W-1:0]     pc;
        logic [CHUNK_IDX_W-1:0] pk;
        q.delete();
        n = 0; last_due = 0; stalled = 0; got = 0;
        order_err = 0; stab_err = 0; obs_lat = -1;
        pc = '0; pk = '0;
        @(negedge clk);
        start = 1'b1;
        s = edge_cnt + 1;
        for (int cyc = 0; cyc < 20000 && !got; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            rsp_valid = 1'b0;
            e = edge_cnt + 1;
            if (result_valid) begin
                got = 1;
                obs_lat = e - s;
                req_ready = 1'b0;
            end else begin
                if (stalled && (!req_valid || req_class != pc || req_chunk != pk)) stab_err++;
                if (q.size() > 0 && q[0].due <= e) begin
                    rsp_valid = 1'b1;
                    rsp_count = CNT_W'(q[0].cnt);
                    void'(q.pop_front());
                end
                req_ready = ($urandom_range(99) < ready_pct);
                if (req_valid && req_ready) begin
                    ec = n / NUM_CHUNKS;
                    ek = n % NUM_CHUNKS;
                    if (int'(req_class) != ec || int'(req_chunk) != ek) order_err++;
                    v = (n < TOTAL) ? cnt_tab[ec][ek] : 0;
                    d = e + int'($urandom_range(lat_max, lat_min));
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    q.push_back('{due: d, cnt: v});
                    n++;
                    if (n == abort_at) break;
                end
                stalled = req_valid && !req_ready;
                pc = req_class;
                pk = req_chunk;
            end
        end
        obs_issued = n;
        if (abort_at < 0) chk("result_timeout", got, 1);
    endtask

    task automatic check_result(input int ec, input int es, input int em, input int el);
        chk("result_class", result_class, ec);
        chk("result_sim", result_sim, es);
`ifdef AM_MARGIN_EN
        chk("result_margin", result_margin, em);
`else
        if (em < 0) chk("margin_arg", em, 0);
`endif
        if (el >= 0) chk("latency", obs_lat, el);
        chk("issued", obs_issued, TOTAL);
        chk("order_errors", order_err, 0);
        chk("stall_errors", stab_err, 0);
        chk("pending_rsp", q.size(), 0);
        chk("done_flags", {busy, req_valid, err_spurious}, 3'b100);
    endtask

    task automatic finish_result(input int hold);
        logic [CLASS_W-1:0] rc;
        logic [SIM_W-1:0]   rs;
        int bad;
        rc = result_class; rs = result_sim; bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            start = (i == 5);
            if (!result_valid || !busy || req_valid || result_class != rc || result_sim != rs) bad++;
        end
        start = 1'b0;
        if (hold > 0) chk("done_hold_stable", bad, 0);
        @(negedge clk);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("idle_after_ack", {busy, result_valid}, 2'b00);
    endtask

    initial begin
        int mc, ms, mm;
        rst = 1'b1; start = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        rsp_count = '0; result_ready = 1'b0;

        //          hot_a hot_b val base rdy lmin lmax hold  class sim   margin lat
        vecs[0] = '{-1,   -1,   0,  0,   100, 2,  2,   0,    0,    0,    0,     1043};
        vecs[1] = '{7,    -1,   100, 50, 100, 2,  2,   20,   7,    4000, 2000,  1043};
        vecs[2] = '{3,    19,   100, 10, 100, 2,  2,   0,    3,    4000, 0,     1043};
        vecs[3] = '{25,   -1,   128, 64, 50,  1,  5,   0,    25,   5120, 2560,  -1};
        vecs[4] = '{0,    -1,   0,   5,  100, 1,  1,   0,    1,    200,  0,     1042};

        repeat (3) @(negedge clk);
        chk("reset_outputs_zero", outputs_zero(), 1);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            fill(vecs[i].hot_a, vecs[i].hot_b, vecs[i].hot_val, vecs[i].base);
            ready_pct = vecs[i].ready_pct;
            lat_min = vecs[i].lat_min;
            lat_max = vecs[i].lat_max;
            run_search(-1);
            check_result(vecs[i].exp_class, vecs[i].exp_sim, vecs[i].exp_margin, vecs[i].exp_lat);
            finish_result(vecs[i].hold);
        end

        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NUM_CLASSES; c++)
                for (int k = 0; k < NUM_CHUNKS; k++)
                    cnt_tab[c][k] = int'($urandom_range(128, 0));
            model(mc, ms, mm);
            ready_pct = 60 + 20 * r;
            lat_min = 1;
            lat_max = 4 + r;
            run_search(-1);
            check_result(mc, ms, mm, -1);
            finish_result(0);
        end

        // Abort mid-search with reset, then a clean search must work.
        fill(7, -1, 100, 50);
        ready_pct = 100; lat_min = 2; lat_max = 2;
        run_search(500);
        chk("abort_point", obs_issued, 500);
        @(negedge clk);
        rst = 1'b1; rsp_valid = 1'b0; req_ready = 1'b0;
        q.delete();
        #1;
        chk("abort_reset_zero", outputs_zero(), 1);
        repeat (2) @(negedge clk);
        chk("abort_reset_hold_zero", outputs_zero(), 1);
        rst = 1'b0;

        fill(12, -1, 90, 0);
        run_search(-1);
        check_result(12, 3600, 3600, 1043);
        finish_result(0);

        chk("no_spurious_yet", err_spurious, 0);
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_count = CNT_W'(5);
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("spurious_in_idle", {err_spurious, busy}, 2'b10);
        repeat (3) @(negedge clk);
        chk("spurious_sticky", err_spurious, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
